// File: rtl/poly_mau_result_sink_if.sv
// Beat input from POLY_MAU and write port toward the coefficient RAM.
// The master view belongs to the result sink; the slave view belongs to the surrounding pipeline and RAM.
interface poly_mau_result_sink_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 8
);
  logic                poly_valid;
  logic [DATA_W-1:0]   poly_mau_o0;
  logic [DATA_W-1:0]   poly_mau_o1;
  logic                ram_wr_en;
  logic [ADDR_W-1:0]   ram_wr_addr;
  logic [2*DATA_W-1:0] ram_wr_data;
  logic                ram_wr_ready;

  modport master (
    input  poly_valid, poly_mau_o0, poly_mau_o1, ram_wr_ready,
    output ram_wr_en, ram_wr_addr, ram_wr_data
  );

  modport slave (
    output poly_valid, poly_mau_o0, poly_mau_o1, ram_wr_ready,
    input  ram_wr_en, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/poly_mau_result_sink.sv
// Collects POLY_MAU result beats into an elastic FIFO and writes them as packed words to consecutive RAM addresses.
// state   | meaning
// IDLE    | waiting for start; beats ignored
// CAPTURE | counting and buffering beats until len reached
// DRAIN   | beats ignored; emptying FIFO into RAM
// DONE    | one-cycle completion pulse
module poly_mau_result_sink #(
  parameter int DATA_W     = 24,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      cfg_base,
  input  logic [ADDR_W:0]        cfg_len,
  poly_mau_result_sink_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [ADDR_W:0]        beat_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    fifo_cnt;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     beat_nxt;
  logic [ADDR_W-1:0]   wr_addr;
  logic fifo_empty, fifo_full, pop, push_req, push, drop, start_ok, last_beat;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign pop        = !fifo_empty && bus.ram_wr_ready;
  assign push_req   = (state == S_CAPTURE) && bus.poly_valid;
  // A full FIFO still accepts a beat when its head leaves in the same cycle.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;
  assign start_ok   = start && (state == S_IDLE);
  assign beat_nxt   = beat_cnt + (ADDR_W+1)'(1);
  assign last_beat  = push_req && (beat_nxt == len_q);

  assign bus.ram_wr_en   = !fifo_empty;
  assign bus.ram_wr_addr = wr_addr;
  assign bus.ram_wr_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = (cfg_len == '0) ? S_DONE : S_CAPTURE;
      S_CAPTURE: if (last_beat) state_nxt = S_DRAIN;
      // Leave as the last write is accepted so DONE lines up with the FIFO going empty.
      S_DRAIN:   if (fifo_empty || (fifo_cnt == CNT_W'(1) && pop)) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_CAPTURE, S_DRAIN: busy = 1'b1;
      S_DONE:             done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {bus.poly_mau_o1, bus.poly_mau_o0};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      beat_cnt <= '0;
      overflow <= 1'b0;
      wr_addr  <= '0;
    end else if (start_ok) begin
      len_q    <= cfg_len;
      beat_cnt <= '0;
      overflow <= 1'b0;
      wr_addr  <= cfg_base;
    end else begin
      if (push_req) beat_cnt <= beat_nxt;
      if (drop)     overflow <= 1'b1;
      if (pop)      wr_addr  <= wr_addr + 1'b1;
    end
  end
endmodule
